// File: rtl/mo_pkg.sv
// Shared definitions for the motion-object horizontal position path:
// FSM state encoding and default geometry constants.
package mo_pkg;

  localparam int MO_POS_WID = 8;
  localparam int MO_PIX     = 16;
  localparam int MO_BPP     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAW  = 2'd2
  } mo_state_e;

endpackage

// File: rtl/mo_gfx_shifter.sv
// Parallel-load, left-shifting graphics row register. The current pixel
// is always the top BPP bits; each shift brings the next pixel up and
// zero-fills from the bottom.
module mo_gfx_shifter #(
  parameter int PIX = 16,
  parameter int BPP = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               shift,
  input  logic [PIX*BPP-1:0] load_val,
  output logic [BPP-1:0]     top_bits
);

  localparam int W = PIX * BPP;

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Next row contents: a load wins over a shift, otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_val;
    end else if (shift) begin
      shreg_d = {shreg_q[W-BPP-1:0], {BPP{1'b0}}};
    end
  end

  // Row register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign top_bits = shreg_q[W-1 -: BPP];

endmodule

// File: rtl/mo_hpos_countdown.sv
// Motion-object horizontal position counter. A line_start pulse arms the
// object with its shadowed position; the position counts down on enabled
// pixel clocks and, once it expires, the shadowed graphics row is shifted
// out one pixel per enabled clock. PIX must be a power of two >= 2.
module mo_hpos_countdown
  import mo_pkg::*;
#(
  parameter int WID = MO_POS_WID,
  parameter int PIX = MO_PIX,
  parameter int BPP = MO_BPP
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               line_start,
  input  logic               ld_n,
  input  logic [WID-1:0]     d,
  input  logic [PIX*BPP-1:0] gfx,
  output logic               busy,
  output logic               rco,
  output logic               pix_valid,
  output logic [BPP-1:0]     pix
);

  localparam int IW = $clog2(PIX);

  mo_state_e          state_q, state_d;
  logic [WID-1:0]     cnt_q, cnt_d;
  logic [WID-1:0]     pos_sh_q, pos_sh_d;
  logic [PIX*BPP-1:0] gfx_sh_q, gfx_sh_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               sh_load;
  logic               sh_shift;
  logic [BPP-1:0]     sh_top;

  // Next-state logic: shadow load is independent of the FSM; line_start
  // re-arms unconditionally (using the pre-load shadow), otherwise the
  // counter/row only advance on enabled pixel clocks.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_sh_d = pos_sh_q;
    gfx_sh_d = gfx_sh_q;
    idx_d    = idx_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;

    if (!ld_n) begin
      pos_sh_d = d;
      gfx_sh_d = gfx;
    end

    if (line_start) begin
      cnt_d   = pos_sh_q;
      idx_d   = '0;
      state_d = ARMED;
      sh_load = 1'b1;
    end else if (en) begin
      case (state_q)
        ARMED: begin
          if (cnt_q == '0) begin
            state_d = DRAW;
          end else begin
            cnt_d = cnt_q - WID'(1);
          end
        end
        DRAW: begin
          sh_shift = 1'b1;
          idx_d    = idx_q + IW'(1);
          if (idx_q == IW'(PIX - 1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, counter and shadow registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pos_sh_q <= '0;
      gfx_sh_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_sh_q <= pos_sh_d;
      gfx_sh_q <= gfx_sh_d;
      idx_q    <= idx_d;
    end
  end

  mo_gfx_shifter #(
    .PIX(PIX),
    .BPP(BPP)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sh_load),
    .shift   (sh_shift),
    .load_val(gfx_sh_q),
    .top_bits(sh_top)
  );

  assign busy      = (state_q == ARMED) || (state_q == DRAW);
  assign rco       = (state_q == ARMED) && (cnt_q == '0) && en;
  assign pix_valid = (state_q == DRAW);
  assign pix       = (state_q == DRAW) ? sh_top : '0;

endmodule

// File: tb/tb_mo_hpos_countdown.sv
// Self-checking bench for mo_hpos_countdown. The reference model tracks
// only how many enabled clocks have elapsed since the last arm, and from
// that count derives which phase the object is in and which pixel shows.
module tb_mo_hpos_countdown;

  localparam int WID = 8;
  localparam int PIX = 16;
  localparam int BPP = 2;
  localparam int GW  = PIX * BPP;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           en = 1'b0;
  logic           line_start = 1'b0;
  logic           ld_n = 1'b1;
  logic [WID-1:0] d = '0;
  logic [GW-1:0]  gfx = '0;
  logic           busy;
  logic           rco;
  logic           pix_valid;
  logic [BPP-1:0] pix;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit            armed_m;
  int            n_m;
  int            arm_p;
  logic [GW-1:0] arm_g;
  int            pos_m;
  logic [GW-1:0] gfx_m;

  always #5 clk = ~clk;

  mo_hpos_countdown #(
    .WID(WID),
    .PIX(PIX),
    .BPP(BPP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .line_start(line_start),
    .ld_n      (ld_n),
    .d         (d),
    .gfx       (gfx),
    .busy      (busy),
    .rco       (rco),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    armed_m = 1'b0;
    n_m     = 0;
    arm_p   = 0;
    arm_g   = '0;
    pos_m   = 0;
    gfx_m   = '0;
  endtask

  // Expected outputs from the number of enabled clocks since the arm:
  // counts 0..P are the countdown, P+1..P+PIX are pixels 0..PIX-1.
  task automatic checkAll(input string tag);
    logic [31:0] eb, er, ev, ep;
    int k;
    eb = 0; er = 0; ev = 0; ep = 0;
    if (armed_m) begin
      if (n_m <= arm_p) begin
        eb = 1;
        er = ((n_m == arm_p) && en) ? 1 : 0;
      end else if (n_m <= arm_p + PIX) begin
        eb = 1;
        ev = 1;
        k  = n_m - arm_p - 1;
        ep = 32'((arm_g >> (GW - BPP * (k + 1))) & GW'((1 << BPP) - 1));
      end
    end
    checkOutput($sformatf("%s.busy", tag), 32'(busy), eb);
    checkOutput($sformatf("%s.rco", tag), 32'(rco), er);
    checkOutput($sformatf("%s.pix_valid", tag), 32'(pix_valid), ev);
    checkOutput($sformatf("%s.pix", tag), 32'(pix), ep);
  endtask

  // Called just after a falling edge: drive, check, clock, update model.
  task automatic applyStimulus(input bit ls, input bit ldn, input logic [WID-1:0] dv,
                               input logic [GW-1:0] gv, input bit e, input string tag);
    line_start = ls;
    ld_n       = ldn;
    d          = dv;
    gfx        = gv;
    en         = e;
    #2;
    checkAll(tag);
    @(posedge clk);
    if (reset_n) begin
      if (ls) begin
        armed_m = 1'b1;
        n_m     = 0;
        arm_p   = pos_m;
        arm_g   = gfx_m;
      end else if (e && armed_m && (n_m <= arm_p + PIX)) begin
        n_m++;
      end
      if (!ldn) begin
        pos_m = int'(dv);
        gfx_m = gv;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    reset_n = 1'b0;
    @(negedge clk);

    // Reset held, en high, nothing should move
    repeat (3) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "reset");
    reset_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "idle");

    // Basic draw at position 5
    applyStimulus(1'b0, 1'b0, 8'd5, 32'hE4E4_E4E4, 1'b1, "load5");
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, "arm5");
    repeat (26) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "draw5");

    // Gapped enable at position 3
    applyStimulus(1'b0, 1'b0, 8'd3, 32'h1B6C_D29F, 1'b0, "load3");
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0, "arm3");
    for (int i = 0; i < 46; i++) applyStimulus(1'b0, 1'b1, '0, '0, i[0] == 1'b0, "gap3");

    // Position 0
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h9C3A_5F06, 1'b1, "load0");
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, "arm0");
    repeat (20) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "draw0");

    // Position 255: long countdown, no wrap
    applyStimulus(1'b0, 1'b0, 8'hFF, 32'hA5A5_0FF0, 1'b1, "loadFF");
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, "armFF");
    repeat (276) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "drawFF");

    // Load coincident with arm: this line uses 10, next line uses 20
    applyStimulus(1'b0, 1'b0, 8'd10, 32'h3210_7654, 1'b1, "load10");
    applyStimulus(1'b1, 1'b0, 8'd20, 32'hFEDC_BA98, 1'b1, "arm10ld20");
    repeat (30) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "draw10");
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, "arm20");
    repeat (28) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "draw20");
    // Now at pixel 7: re-arm aborts the row
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, "abort");
    repeat (40) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "rearm");

    // Async reset mid-draw
    applyStimulus(1'b0, 1'b0, 8'd2, 32'hC3C3_C3C3, 1'b1, "load2");
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1, "arm2");
    repeat (6) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "draw2");
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkAll("async");
    @(negedge clk);
    repeat (2) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "inreset");
    reset_n = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, "postreset");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit            ls, ldn, e;
      logic [WID-1:0] dv;
      logic [GW-1:0]  gv;
      ls  = ($urandom_range(0, 59) == 0);
      ldn = ($urandom_range(0, 9) != 0);
      dv  = ($urandom_range(0, 19) == 0) ? 8'hFF : WID'($urandom_range(0, 40));
      gv  = GW'($urandom);
      e   = ($urandom_range(0, 3) != 0);
      applyStimulus(ls, ldn, dv, gv, e, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
